// File: rtl/err_gen_pkg.sv
// Shared types and helpers for the square-wave error demodulator.
// Holds the FSM state encoding, the default averaging limit and the error saturation helper.
package err_gen_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StSettle   = 3'd1,
    StAcq      = 3'd2,
    StEmit     = 3'd3,
    StWaitTrig = 3'd4
  } state_e;

  localparam int unsigned AvgLog2MaxDef = 6;

  // Widest error word the clamp helper supports; callers sign-extend into it.
  localparam int unsigned MaxErrW = 64;
  localparam int unsigned ClampW  = MaxErrW + 1;

  typedef struct packed {
    logic                      sat;
    logic signed [MaxErrW-1:0] val;
  } clamp_t;

  // Saturate an (w+1)-bit signed value, carried sign-extended in ClampW bits, to w bits.
  function automatic clamp_t clamp_err(input logic signed [ClampW-1:0] x, input int unsigned w);
    logic signed [ClampW-1:0] hi;
    logic signed [ClampW-1:0] lo;
    clamp_t                   r;
    hi    = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo    = -(65'sd1 <<< (w - 1));
    r.sat = 1'b0;
    r.val = MaxErrW'(x);
    if (x > hi) begin
      r.sat = 1'b1;
      r.val = MaxErrW'(hi);
    end else if (x < lo) begin
      r.sat = 1'b1;
      r.val = MaxErrW'(lo);
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_window_acc.sv
// Accumulates ADC samples over a power-of-two window and presents the arithmetic mean.
module adc_window_acc #(
  parameter int unsigned ADC_BIT      = 14,
  parameter int unsigned AVG_LOG2_MAX = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      acc_en,
  input  logic [2:0]                n,
  input  logic signed [ADC_BIT-1:0] sample,
  output logic                      done,
  output logic signed [ADC_BIT-1:0] mean
);

  localparam int unsigned SumW = ADC_BIT + AVG_LOG2_MAX + 1;
  localparam int unsigned CntW = AVG_LOG2_MAX + 1;

  logic signed [SumW-1:0] sum_q;
  logic [CntW-1:0]        cnt_q;
  logic [CntW-1:0]        last;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else if (acc_en) begin
      sum_q <= sum_q + SumW'(sample);
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  always_comb begin
    last = (CntW'(1) << n) - CntW'(1);
    done = (cnt_q == last);
  end

  // Mean of in-range samples always fits back into the sample width.
  assign mean = ADC_BIT'(sum_q >>> n);

endmodule

// File: rtl/err_signal_gen_v3.sv
// Closed-loop FOG error demodulator: settle, average a half-period, emit the signed
// alternating difference of consecutive means plus offset, saturated, with a valid strobe.
module err_signal_gen_v3
  import err_gen_pkg::*;
#(
  parameter int unsigned ADC_BIT      = 14,
  parameter int unsigned ERR_W        = 32,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned AVG_LOG2_MAX = AvgLog2MaxDef
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic                      i_polarity,
  input  logic                      i_trig,
  input  logic [CNT_W-1:0]          i_settle_cnt,
  input  logic [2:0]                i_avg_log2,
  input  logic signed [ERR_W-1:0]   i_err_offset,
  input  logic signed [ADC_BIT-1:0] i_adc_data,
  output logic signed [ERR_W-1:0]   o_err,
  output logic                      o_err_valid,
  output logic                      o_sat,
  output logic                      o_miss,
  output logic [2:0]                o_state
);

  localparam int unsigned EW1 = ERR_W + 1;

  state_e                    state_q, state_d;
  logic signed [ADC_BIT-1:0] r_adc_q;
  logic                      r_trig_q, r_pol_q, r_pol_prev_q, r_en_q;
  logic [CNT_W-1:0]          settle_q, settle_d;
  logic [2:0]                cfg_n_q;
  logic signed [ERR_W-1:0]   cfg_off_q;
  logic signed [ADC_BIT-1:0] old_q;
  logic                      flip_q, init_q;
  logic signed [ERR_W-1:0]   err_q;
  logic                      valid_q, sat_q, miss_q;

  logic                      rearm, accept, miss, emit, acc_clr, acc_en, acc_done;
  logic [2:0]                n_lim;
  logic signed [ADC_BIT-1:0] acc_mean;
  logic signed [ERR_W:0]     mean_ext, old_ext, off_ext, diff, err_wide;
  clamp_t                    clamp_r;
  logic signed [ERR_W-1:0]   err_clamped;

  adc_window_acc #(
    .ADC_BIT      (ADC_BIT),
    .AVG_LOG2_MAX (AVG_LOG2_MAX)
  ) u_acc (
    .clk    (i_clk),
    .rst    (i_rst),
    .clr    (acc_clr),
    .acc_en (acc_en),
    .n      (cfg_n_q),
    .sample (r_adc_q),
    .done   (acc_done),
    .mean   (acc_mean)
  );

  assign n_lim = (i_avg_log2 > 3'(AVG_LOG2_MAX)) ? 3'(AVG_LOG2_MAX) : i_avg_log2;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    accept   = 1'b0;
    miss     = 1'b0;
    emit     = 1'b0;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    rearm    = ~r_en_q | (r_pol_q != r_pol_prev_q);
    if (rearm) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (r_trig_q) begin
            accept  = 1'b1;
            state_d = StSettle;
          end
        end
        StSettle: begin
          acc_clr = 1'b1;
          if (r_trig_q) begin
            miss   = 1'b1;
            accept = 1'b1;
          end else if (settle_q == '0) begin
            state_d = StAcq;
          end else begin
            settle_d = settle_q - CNT_W'(1);
          end
        end
        StAcq: begin
          if (r_trig_q) begin
            miss    = 1'b1;
            accept  = 1'b1;
            state_d = StSettle;
          end else begin
            acc_en = 1'b1;
            if (acc_done) state_d = StEmit;
          end
        end
        StEmit: begin
          emit = 1'b1;
          if (r_trig_q) begin
            accept  = 1'b1;
            state_d = StSettle;
          end else begin
            state_d = StWaitTrig;
          end
        end
        StWaitTrig: begin
          if (r_trig_q) begin
            accept  = 1'b1;
            state_d = StSettle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (accept) settle_d = i_settle_cnt;
  end

  // Difference is taken one bit wider than the output so the offset add cannot wrap.
  always_comb begin
    mean_ext    = EW1'(acc_mean);
    old_ext     = EW1'(old_q);
    off_ext     = EW1'(cfg_off_q);
    diff        = flip_q ? (old_ext - mean_ext) : (mean_ext - old_ext);
    err_wide    = diff + off_ext;
    clamp_r     = clamp_err(ClampW'(err_wide), ERR_W);
    err_clamped = ERR_W'(clamp_r.val);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      r_adc_q      <= '0;
      r_trig_q     <= 1'b0;
      r_pol_q      <= 1'b0;
      r_pol_prev_q <= 1'b0;
      r_en_q       <= 1'b0;
      settle_q     <= '0;
      cfg_n_q      <= '0;
      cfg_off_q    <= '0;
      old_q        <= '0;
      flip_q       <= 1'b0;
      init_q       <= 1'b1;
      err_q        <= '0;
      valid_q      <= 1'b0;
      sat_q        <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      r_adc_q      <= i_adc_data;
      r_trig_q     <= i_trig;
      r_pol_q      <= i_polarity;
      r_pol_prev_q <= r_pol_q;
      r_en_q       <= i_en;
      state_q      <= state_d;
      settle_q     <= settle_d;
      miss_q       <= miss;
      valid_q      <= 1'b0;
      if (accept) begin
        cfg_n_q   <= n_lim;
        cfg_off_q <= i_err_offset;
      end
      if (state_q == StIdle) begin
        init_q <= 1'b1;
        flip_q <= ~r_pol_q;
      end else if (emit) begin
        old_q <= acc_mean;
        if (init_q) begin
          init_q <= 1'b0;
        end else begin
          err_q   <= err_clamped;
          sat_q   <= clamp_r.sat;
          valid_q <= 1'b1;
          flip_q  <= ~flip_q;
        end
      end
    end
  end

  assign o_err       = err_q;
  assign o_err_valid = valid_q;
  assign o_sat       = sat_q;
  assign o_miss      = miss_q;
  assign o_state     = state_q;

endmodule
